// File: rtl/fmap_tile_rd_agen.sv
// -----------------------------------------------------------------------------
// fmap_tile_rd_agen
//
// This block generates AXI read-address bursts for input-buffer tile fetch.
// The walk order, from innermost to outermost loop, is:
//   bursts-in-row (b) -> rows-in-tile (r) -> tiles (x) -> tile rows (y)
//   -> channels (c)
// Each burst address is
//   base + c*ch_pitch + y*blkrow_pitch + x*blk_pitch + r*row_pitch
//        + b*BURST_LEN*BEAT_BYTES
// It is computed incrementally from a chain of base registers, one per loop
// level. No multipliers are used.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   cfg_*             job configuration, captured on the cfg_start accepted in IDLE
//   buf_ready         the input buffer has room for one more burst
//   araddr/arvalid/arready/arlen/arsize/arburst
//                     AXI AR channel (arlen, arsize and arburst are constants)
//   rlast_hs          one pulse per completed read burst
//   blkend / mapend   pulses with the rlast_hs that completes a tile / channel
//   busy              high whenever the FSM is not in IDLE
//   done              high in the cycle where DRAIN returns to IDLE
//   err               sticky; set by rlast_hs with nothing outstanding
//
// AR handshake: arvalid rises only in ISSUE with a free credit and buf_ready.
// Once arvalid is high, arvalid and araddr hold until arready, whatever
// buf_ready does. A burst transfers on any cycle with arvalid & arready.
// -----------------------------------------------------------------------------
module fmap_tile_rd_agen #(
  parameter int AW         = 32,
  parameter int CW         = 8,
  parameter int BURST_LEN  = 16,
  parameter int BEAT_BYTES = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic [AW-1:0] cfg_base,
  input  logic [AW-1:0] cfg_row_pitch,
  input  logic [AW-1:0] cfg_blk_pitch,
  input  logic [AW-1:0] cfg_blkrow_pitch,
  input  logic [AW-1:0] cfg_ch_pitch,
  input  logic [CW-1:0] cfg_nburst,
  input  logic [CW-1:0] cfg_nrow,
  input  logic [CW-1:0] cfg_nblk,
  input  logic [CW-1:0] cfg_nblkrow,
  input  logic [CW-1:0] cfg_nch,
  input  logic          buf_ready,
  output logic [AW-1:0] araddr,
  output logic          arvalid,
  input  logic          arready,
  output logic [7:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  input  logic          rlast_hs,
  output logic          blkend,
  output logic          mapend,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int              OW          = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0]   OUTST_MAX   = OW'(MAX_OUTST);
  localparam logic [OW-1:0]   OUTST_ONE   = OW'(1);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [AW-1:0]   BURST_BYTES = AW'(BURST_LEN * BEAT_BYTES);

  logic [1:0]    state_q;
  logic [AW-1:0] row_pitch_q, blk_pitch_q, blkrow_pitch_q, ch_pitch_q;
  logic [CW-1:0] nburst_q, nrow_q, nblk_q, nblkrow_q, nch_q;

  // Issue-side loop counters and the base-address chain.
  logic [CW-1:0] b_q, r_q, x_q, y_q, c_q;
  logic [AW-1:0] ch_base_q, blkrow_base_q, blk_base_q, row_base_q, addr_q;

  // Return-side counters. These advance on rlast_hs only.
  logic [CW-1:0] ret_b_q, ret_r_q, ret_x_q, ret_y_q;

  logic          arvalid_q;
  logic [OW-1:0] outst_q;
  logic          err_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic          hs, rlast_ok, rlast_bad, start_ok, cfg_zero, issue_ok;
  logic          last_burst, tile_end, map_end;
  logic          arvalid_d, err_d;
  logic [OW-1:0] outst_d;
  logic [CW-1:0] b_d, r_d, x_d, y_d, c_d;
  logic [AW-1:0] ch_base_d, blkrow_base_d, blk_base_d, row_base_d, addr_d;
  logic [CW-1:0] ret_b_d, ret_r_d, ret_x_d, ret_y_d;

  assign hs        = arvalid_q & arready;
  assign rlast_ok  = rlast_hs & (outst_q != '0);
  assign rlast_bad = rlast_hs & (outst_q == '0);
  assign start_ok  = cfg_start & (state_q == ST_IDLE);
  assign cfg_zero  = (cfg_nburst == '0) | (cfg_nrow == '0) | (cfg_nblk == '0) |
                     (cfg_nblkrow == '0) | (cfg_nch == '0);

  // Next burst position. When a loop level wraps, the next outer level steps
  // its base. All inner bases (and the burst address) are reloaded from it.
  always_comb begin
    b_d           = b_q;
    r_d           = r_q;
    x_d           = x_q;
    y_d           = y_q;
    c_d           = c_q;
    ch_base_d     = ch_base_q;
    blkrow_base_d = blkrow_base_q;
    blk_base_d    = blk_base_q;
    row_base_d    = row_base_q;
    addr_d        = addr_q;
    last_burst    = 1'b0;
    if (b_q != nburst_q - CNT_ONE) begin
      b_d    = b_q + CNT_ONE;
      addr_d = addr_q + BURST_BYTES;
    end else begin
      b_d = '0;
      if (r_q != nrow_q - CNT_ONE) begin
        r_d        = r_q + CNT_ONE;
        row_base_d = row_base_q + row_pitch_q;
        addr_d     = row_base_d;
      end else begin
        r_d = '0;
        if (x_q != nblk_q - CNT_ONE) begin
          x_d        = x_q + CNT_ONE;
          blk_base_d = blk_base_q + blk_pitch_q;
          row_base_d = blk_base_d;
          addr_d     = blk_base_d;
        end else begin
          x_d = '0;
          if (y_q != nblkrow_q - CNT_ONE) begin
            y_d           = y_q + CNT_ONE;
            blkrow_base_d = blkrow_base_q + blkrow_pitch_q;
            blk_base_d    = blkrow_base_d;
            row_base_d    = blkrow_base_d;
            addr_d        = blkrow_base_d;
          end else begin
            y_d = '0;
            if (c_q != nch_q - CNT_ONE) begin
              c_d           = c_q + CNT_ONE;
              ch_base_d     = ch_base_q + ch_pitch_q;
              blkrow_base_d = ch_base_d;
              blk_base_d    = ch_base_d;
              row_base_d    = ch_base_d;
              addr_d        = ch_base_d;
            end else begin
              c_d        = '0;
              last_burst = 1'b1;
            end
          end
        end
      end
    end
  end

  // A simultaneous issue and return leave the count unchanged.
  always_comb begin
    outst_d = outst_q;
    if (hs && !rlast_ok) begin
      outst_d = outst_q + OUTST_ONE;
    end else if (!hs && rlast_ok) begin
      outst_d = outst_q - OUTST_ONE;
    end
  end

  // The credit check uses the post-edge count. A handshake that fills the
  // last credit therefore cannot present a burst that would overrun it.
  assign issue_ok = (outst_d < OUTST_MAX) & buf_ready;

  always_comb begin
    if (arvalid_q) begin
      arvalid_d = !arready || (!last_burst && issue_ok);
    end else begin
      arvalid_d = (state_q == ST_ISSUE) && issue_ok;
    end
  end

  always_comb begin
    err_d = err_q;
    if (start_ok) begin
      err_d = 1'b0;
    end
    if (rlast_bad) begin
      err_d = 1'b1;
    end
  end

  // Return-side tracking. AXI returns same-ID bursts in order, so counting
  // returned bursts through the same loop nest identifies tile and map ends.
  assign tile_end = (ret_b_q == nburst_q - CNT_ONE) && (ret_r_q == nrow_q - CNT_ONE);
  assign map_end  = tile_end && (ret_x_q == nblk_q - CNT_ONE) &&
                    (ret_y_q == nblkrow_q - CNT_ONE);

  always_comb begin
    ret_b_d = ret_b_q;
    ret_r_d = ret_r_q;
    ret_x_d = ret_x_q;
    ret_y_d = ret_y_q;
    if (ret_b_q != nburst_q - CNT_ONE) begin
      ret_b_d = ret_b_q + CNT_ONE;
    end else begin
      ret_b_d = '0;
      if (ret_r_q != nrow_q - CNT_ONE) begin
        ret_r_d = ret_r_q + CNT_ONE;
      end else begin
        ret_r_d = '0;
        if (ret_x_q != nblk_q - CNT_ONE) begin
          ret_x_d = ret_x_q + CNT_ONE;
        end else begin
          ret_x_d = '0;
          if (ret_y_q != nblkrow_q - CNT_ONE) begin
            ret_y_d = ret_y_q + CNT_ONE;
          end else begin
            ret_y_d = '0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      row_pitch_q    <= '0;
      blk_pitch_q    <= '0;
      blkrow_pitch_q <= '0;
      ch_pitch_q     <= '0;
      nburst_q       <= '0;
      nrow_q         <= '0;
      nblk_q         <= '0;
      nblkrow_q      <= '0;
      nch_q          <= '0;
      b_q            <= '0;
      r_q            <= '0;
      x_q            <= '0;
      y_q            <= '0;
      c_q            <= '0;
      ch_base_q      <= '0;
      blkrow_base_q  <= '0;
      blk_base_q     <= '0;
      row_base_q     <= '0;
      addr_q         <= '0;
      ret_b_q        <= '0;
      ret_r_q        <= '0;
      ret_x_q        <= '0;
      ret_y_q        <= '0;
      arvalid_q      <= 1'b0;
      outst_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      outst_q   <= outst_d;
      err_q     <= err_d;

      if (rlast_ok) begin
        ret_b_q <= ret_b_d;
        ret_r_q <= ret_r_d;
        ret_x_q <= ret_x_d;
        ret_y_q <= ret_y_d;
      end

      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            row_pitch_q    <= cfg_row_pitch;
            blk_pitch_q    <= cfg_blk_pitch;
            blkrow_pitch_q <= cfg_blkrow_pitch;
            ch_pitch_q     <= cfg_ch_pitch;
            nburst_q       <= cfg_nburst;
            nrow_q         <= cfg_nrow;
            nblk_q         <= cfg_nblk;
            nblkrow_q      <= cfg_nblkrow;
            nch_q          <= cfg_nch;
            b_q            <= '0;
            r_q            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            c_q            <= '0;
            ch_base_q      <= cfg_base;
            blkrow_base_q  <= cfg_base;
            blk_base_q     <= cfg_base;
            row_base_q     <= cfg_base;
            addr_q         <= cfg_base;
            ret_b_q        <= '0;
            ret_r_q        <= '0;
            ret_x_q        <= '0;
            ret_y_q        <= '0;
            state_q        <= cfg_zero ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            b_q           <= b_d;
            r_q           <= r_d;
            x_q           <= x_d;
            y_q           <= y_d;
            c_q           <= c_d;
            ch_base_q     <= ch_base_d;
            blkrow_base_q <= blkrow_base_d;
            blk_base_q    <= blk_base_d;
            row_base_q    <= row_base_d;
            addr_q        <= addr_d;
            if (last_burst) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (outst_q == '0) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign araddr  = addr_q;
  assign arvalid = arvalid_q;
  assign arlen   = 8'(BURST_LEN - 1);
  assign arsize  = 3'($clog2(BEAT_BYTES));
  assign arburst = 2'b01;
  assign blkend  = rlast_ok & tile_end;
  assign mapend  = rlast_ok & map_end;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DRAIN) && (outst_q == '0);
  assign err     = err_q;

endmodule

// File: tb/tb_fmap_tile_rd_agen.sv
// -----------------------------------------------------------------------------
// tb_fmap_tile_rd_agen
// Bench for fmap_tile_rd_agen. Default parameters are used: BURST_LEN=16 and
// BEAT_BYTES=4, so one burst spans 64 bytes.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fmap_tile_rd_agen;

  localparam int RSP_DELAY = 3;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [31:0] cfg_base, cfg_row_pitch, cfg_blk_pitch, cfg_blkrow_pitch, cfg_ch_pitch;
  logic [7:0]  cfg_nburst, cfg_nrow, cfg_nblk, cfg_nblkrow, cfg_nch;
  logic        buf_ready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rlast_hs;
  logic        blkend, mapend, busy, done, err;

  fmap_tile_rd_agen dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_base(cfg_base), .cfg_row_pitch(cfg_row_pitch), .cfg_blk_pitch(cfg_blk_pitch),
    .cfg_blkrow_pitch(cfg_blkrow_pitch), .cfg_ch_pitch(cfg_ch_pitch),
    .cfg_nburst(cfg_nburst), .cfg_nrow(cfg_nrow), .cfg_nblk(cfg_nblk),
    .cfg_nblkrow(cfg_nblkrow), .cfg_nch(cfg_nch), .buf_ready(buf_ready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .rlast_hs(rlast_hs), .blkend(blkend),
    .mapend(mapend), .busy(busy), .done(done), .err(err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard and bookkeeping
  logic [31:0] exp_q[$];
  int          rsp_q[$];
  int          blk_idx[$];
  int          map_idx[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          hs_total = 0, rl_total = 0, done_total = 0;
  int          hs0, rl0, done0;
  int          inject_n = 0;
  bit          rsp_en = 1'b1;

  // The tick task advances one clock cycle. On the falling edge it samples
  // the DUT and retires AR handshakes against the expected queue. On the
  // rising edge plus 1 ns it plays the read-response model.
  task automatic tick();
    logic [31:0] exp_a;
    bit          hs_pend;
    @(negedge clk);
    hs_pend = arvalid && arready;
    if (hs_pend) begin
      hs_total++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ar_unexpected: got araddr=%h, required no burst", araddr);
      end else begin
        exp_a = exp_q.pop_front();
        if (araddr !== exp_a) begin
          n_fail++;
          $display("FAIL ar_addr: got %h, required %h", araddr, exp_a);
        end
      end
      n_cmp++;
      if ({arlen, arsize, arburst} !== {8'd15, 3'd2, 2'b01}) begin
        n_fail++;
        $display("FAIL ar_consts: got len=%0d size=%0d burst=%0d, required 15/2/1",
                 arlen, arsize, arburst);
      end
    end
    if (rlast_hs) rl_total++;
    if (blkend || mapend) begin
      n_cmp++;
      if (!rlast_hs) begin
        n_fail++;
        $display("FAIL end_without_rlast: got blkend=%b mapend=%b, required rlast_hs=1",
                 blkend, mapend);
      end
    end
    if (blkend) blk_idx.push_back(rl_total);
    if (mapend) map_idx.push_back(rl_total);
    if (done) done_total++;
    @(posedge clk);
    #1;
    rlast_hs = 1'b0;
    if (!rst_n) begin
      rsp_q.delete();
    end else begin
      for (int i = 0; i < rsp_q.size(); i++) rsp_q[i] = rsp_q[i] - 1;
      if (rsp_q.size() > 0 && rsp_q[0] <= 0) begin
        rsp_q.delete(0);
        rlast_hs = 1'b1;
      end else if (inject_n > 0) begin
        inject_n--;
        rlast_hs = 1'b1;
      end
      if (hs_pend && rsp_en) rsp_q.push_back(RSP_DELAY);
    end
  endtask

  // Driver for one job. It queues the expected addresses from the closed-form
  // formula, pulses cfg_start, and then scrambles cfg_* so that latching is
  // exercised.
  task automatic start_job(input logic [31:0] base, input logic [31:0] rowp,
                           input logic [31:0] blkp, input logic [31:0] blkrowp,
                           input logic [31:0] chp, input int nb, input int nr,
                           input int nx, input int ny, input int nc);
    logic [31:0] a;
    cfg_base = base; cfg_row_pitch = rowp; cfg_blk_pitch = blkp;
    cfg_blkrow_pitch = blkrowp; cfg_ch_pitch = chp;
    cfg_nburst = 8'(nb); cfg_nrow = 8'(nr); cfg_nblk = 8'(nx);
    cfg_nblkrow = 8'(ny); cfg_nch = 8'(nc);
    for (int c = 0; c < nc; c++)
      for (int y = 0; y < ny; y++)
        for (int x = 0; x < nx; x++)
          for (int r = 0; r < nr; r++)
            for (int b = 0; b < nb; b++) begin
              a = base + 32'(c) * chp + 32'(y) * blkrowp + 32'(x) * blkp +
                  32'(r) * rowp + 32'(b) * 32'd64;
              exp_q.push_back(a);
            end
    hs0 = hs_total; rl0 = rl_total; done0 = done_total;
    blk_idx.delete(); map_idx.delete();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_base = $urandom(); cfg_row_pitch = $urandom(); cfg_blk_pitch = $urandom();
    cfg_blkrow_pitch = $urandom(); cfg_ch_pitch = $urandom();
    cfg_nburst = 8'($urandom_range(1, 255)); cfg_nrow = 8'($urandom_range(1, 255));
    cfg_nblk = 8'($urandom_range(1, 255)); cfg_nblkrow = 8'($urandom_range(1, 255));
    cfg_nch = 8'($urandom_range(1, 255));
  endtask

  task automatic run_job(input int budget, output bit timed_out);
    int n;
    n = 0;
    while (done_total == done0 && n < budget) begin
      tick();
      n++;
    end
    timed_out = (done_total == done0);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b, required 0", arvalid); end
    n_cmp++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h, required 0", araddr); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    n_cmp++; if ({blkend, mapend} !== 2'b00) begin n_fail++; $display("FAIL reset_ends: got %b, required 00", {blkend, mapend}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_tile();
    bit to;
    start_job(32'h1000, 32'h380, 32'h0, 32'h0, 32'h0, 2, 3, 1, 1, 1);
    n_cmp++; if (busy !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL single_start: got busy=%b arvalid=%b, required 1/0", busy, arvalid); end
    tick();
    n_cmp++; if (arvalid !== 1'b1 || araddr !== 32'h1000) begin n_fail++; $display("FAIL single_first_ar: got arvalid=%b araddr=%h, required 1/00001000", arvalid, araddr); end
    // Four credits are free, so the first four bursts transfer back to back.
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (hs_total - hs0 != 4) begin n_fail++; $display("FAIL single_back_to_back: got %0d handshakes, required 4", hs_total - hs0); end
    run_job(200, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL single_timeout: got no done, required done"); end
    n_cmp++; if (hs_total - hs0 != 6) begin n_fail++; $display("FAIL single_hs: got %0d, required 6", hs_total - hs0); end
    n_cmp++; if (blk_idx.size() != 1 || blk_idx[0] - rl0 != 6) begin n_fail++; $display("FAIL single_blkend: got %0d pulses, required 1 at rlast 6", blk_idx.size()); end
    n_cmp++; if (map_idx.size() != 1 || map_idx[0] - rl0 != 6) begin n_fail++; $display("FAIL single_mapend: got %0d pulses, required 1 at rlast 6", map_idx.size()); end
    n_cmp++; if (busy !== 1'b0 || exp_q.size() != 0) begin n_fail++; $display("FAIL single_end: got busy=%b left=%0d, required 0/0", busy, exp_q.size()); end
  endtask

  task automatic test_two_tiles();
    bit to;
    start_job(32'h1000, 32'h380, 32'h80, 32'h0, 32'h0, 2, 3, 2, 1, 1);
    run_job(300, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL tiles_timeout: got no done, required done"); end
    n_cmp++; if (hs_total - hs0 != 12 || exp_q.size() != 0) begin n_fail++; $display("FAIL tiles_hs: got %0d left %0d, required 12/0", hs_total - hs0, exp_q.size()); end
    n_cmp++; if (blk_idx.size() != 2 || blk_idx[0] - rl0 != 6 || blk_idx[1] - rl0 != 12) begin n_fail++; $display("FAIL tiles_blkend: got %0d pulses, required 2 at rlast 6 and 12", blk_idx.size()); end
    n_cmp++; if (map_idx.size() != 1 || map_idx[0] - rl0 != 12) begin n_fail++; $display("FAIL tiles_mapend: got %0d pulses, required 1 at rlast 12", map_idx.size()); end
  endtask

  task automatic test_two_channels();
    bit to;
    start_job(32'h1000, 32'h380, 32'h0, 32'h0, 32'h10000, 2, 3, 1, 1, 2);
    run_job(300, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL chan_timeout: got no done, required done"); end
    n_cmp++; if (map_idx.size() != 2 || map_idx[0] - rl0 != 6 || map_idx[1] - rl0 != 12) begin n_fail++; $display("FAIL chan_mapend: got %0d pulses, required 2 at rlast 6 and 12", map_idx.size()); end
    n_cmp++; if (blk_idx.size() != 2) begin n_fail++; $display("FAIL chan_blkend: got %0d, required 2", blk_idx.size()); end
    tick(); tick();
    n_cmp++; if (done_total - done0 != 1) begin n_fail++; $display("FAIL chan_done: got %0d pulses, required 1", done_total - done0); end
  endtask

  task automatic test_ar_hold();
    bit to;
    int n;
    arready = 1'b0;
    start_job(32'h1000, 32'h380, 32'h0, 32'h0, 32'h0, 2, 3, 1, 1, 1);
    n = 0;
    while (!arvalid && n < 10) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      if (k == 1) buf_ready = 1'b0;
      tick();
      n_cmp++;
      if (arvalid !== 1'b1 || araddr !== 32'h1000) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got arvalid=%b araddr=%h, required 1/00001000", k, arvalid, araddr);
      end
    end
    arready = 1'b1;
    buf_ready = 1'b1;
    run_job(200, to);
    n_cmp++; if (to || hs_total - hs0 != 6) begin n_fail++; $display("FAIL hold_finish: got timeout=%b hs=%0d, required 0/6", to, hs_total - hs0); end
  endtask

  task automatic test_outstanding();
    bit to;
    rsp_en = 1'b0;
    start_job(32'h1000, 32'h380, 32'h0, 32'h0, 32'h0, 2, 3, 1, 1, 1);
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (hs_total - hs0 != 4 || arvalid !== 1'b0) begin n_fail++; $display("FAIL outst_cap: got hs=%0d arvalid=%b, required 4/0", hs_total - hs0, arvalid); end
    inject_n = 1;
    for (int i = 0; i < 6; i++) tick();
    n_cmp++; if (hs_total - hs0 != 5 || arvalid !== 1'b0) begin n_fail++; $display("FAIL outst_release: got hs=%0d arvalid=%b, required 5/0", hs_total - hs0, arvalid); end
    rsp_en = 1'b1;
    inject_n = 4;
    run_job(200, to);
    n_cmp++; if (to || rl_total - rl0 != 6) begin n_fail++; $display("FAIL outst_finish: got timeout=%b rlast=%0d, required 0/6", to, rl_total - rl0); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL outst_err: got %b, required 0", err); end
  endtask

  task automatic test_err();
    inject_n = 1;
    tick(); tick();
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_idle: got err=%b busy=%b, required 1/0", err, busy); end
    tick();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, required 1", err); end
  endtask

  task automatic test_zero();
    start_job(32'h2000, 32'h380, 32'h0, 32'h0, 32'h0, 2, 0, 1, 1, 1);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL zero_err_clear: got %b, required 0", err); end
    n_cmp++; if (busy !== 1'b1 || done !== 1'b1 || arvalid !== 1'b0) begin n_fail++; $display("FAIL zero_drain: got busy=%b done=%b arvalid=%b, required 1/1/0", busy, done, arvalid); end
    tick(); tick();
    n_cmp++; if (busy !== 1'b0 || hs_total != hs0 || done_total - done0 != 1) begin n_fail++; $display("FAIL zero_end: got busy=%b hs=%0d done=%0d, required 0/0/1", busy, hs_total - hs0, done_total - done0); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    start_job(32'h4000, 32'h400, 32'h0, 32'h0, 32'h0, 4, 4, 1, 1, 1);
    n = 0;
    while (hs_total - hs0 < 2 && n < 20) begin tick(); n++; end
    rst_n = 1'b0;
    rlast_hs = 1'b0;
    #1;
    n_cmp++; if (arvalid !== 1'b0 || busy !== 1'b0 || araddr !== 32'h0) begin n_fail++; $display("FAIL rst_mid: got arvalid=%b busy=%b araddr=%h, required 0/0/0", arvalid, busy, araddr); end
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start_job(32'h1000, 32'h380, 32'h0, 32'h0, 32'h0, 2, 3, 1, 1, 1);
    run_job(200, to);
    n_cmp++; if (to || rl_total - rl0 != 6 || err !== 1'b0) begin n_fail++; $display("FAIL rst_recover: got timeout=%b rlast=%0d err=%b, required 0/6/0", to, rl_total - rl0, err); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; buf_ready = 1'b1; arready = 1'b1; rlast_hs = 1'b0;
    cfg_base = '0; cfg_row_pitch = '0; cfg_blk_pitch = '0; cfg_blkrow_pitch = '0;
    cfg_ch_pitch = '0; cfg_nburst = '0; cfg_nrow = '0; cfg_nblk = '0;
    cfg_nblkrow = '0; cfg_nch = '0;
    test_reset();
    test_single_tile();
    test_two_tiles();
    test_two_channels();
    test_ar_hold();
    test_outstanding();
    test_err();
    test_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fmap_tile_rd_agen.md
Name: fmap_tile_rd_agen

Overview:
Runtime-configurable AXI read-address generator for input-buffer tile fetch; successor to the fixed-geometry input-buffer address generator. Walks channels -> tile rows -> tiles -> rows-in-tile -> bursts-in-row.
- Issues AR bursts with a full valid/ready handshake, outstanding-burst credit and downstream-buffer flow control.
- Flags tile/map completion from returned rlast.
- Sits between the layer controller (cfg_*) and the AXI read master feeding the input line buffers.

Parameters:
AW, 32, address width
CW, 8, width of every count field (tile geometry and channels)
BURST_LEN, 16, beats per burst (1..256)
BEAT_BYTES, 4, bytes per beat (power of 2, <=128)
MAX_OUTST, 4, maximum AR bursts in flight (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
cfg_start  in  1  one-cycle start pulse; sampled only in IDLE
cfg_base  in  AW  byte address of channel 0, tile (0,0)
cfg_row_pitch  in  AW  bytes between consecutive image rows
cfg_blk_pitch  in  AW  bytes between horizontally adjacent tiles
cfg_blkrow_pitch  in  AW  bytes between vertically adjacent tile rows
cfg_ch_pitch  in  AW  bytes between channel planes
cfg_nburst  in  CW  bursts per tile row
cfg_nrow  in  CW  rows per tile
cfg_nblk  in  CW  tiles per tile row
cfg_nblkrow  in  CW  tile rows per map
cfg_nch  in  CW  channels (maps)
buf_ready  in  1  input buffer can accept one more burst
araddr  out  AW  burst start address
arvalid  out  1  AR valid
arready  in  1  AR ready
arlen  out  8  constant BURST_LEN-1
arsize  out  3  constant log2(BEAT_BYTES)
arburst  out  2  constant 2'b01 (INCR)
rlast_hs  in  1  one pulse per completed burst (rvalid&rready&rlast)
blkend  out  1  pulse: last burst of a tile returned
mapend  out  1  pulse: last burst of a channel returned
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when the job finishes
err  out  1  sticky; rlast_hs with zero outstanding; cleared by cfg_start

Behaviour:
- Reset values: arvalid, araddr, blkend, mapend, busy, done, err = 0; FSM in IDLE; all counters and bases = 0.
- cfg_* latched on the accepted cfg_start; later changes have no effect until the next job.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on cfg_start.
  - If any count field is 0, IDLE -> DRAIN directly: no AR is issued, and done pulses once outstanding is 0.
  - ISSUE -> DRAIN on the AR handshake of the final burst.
  - DRAIN -> IDLE when outstanding==0; done pulses in that same cycle.
  - cfg_start outside IDLE is ignored.
- Address: araddr = base + c*ch_pitch + y*blkrow_pitch + x*blk_pitch + r*row_pitch + b*BURST_LEN*BEAT_BYTES, all mod 2^AW.
  - Computed incrementally from registered channel, tile-row, tile and row base registers; no multipliers.
  - Loop order, innermost first: b, r, x, y, c.
- Issue rules:
  - arvalid may rise when state==ISSUE, outst<MAX_OUTST and buf_ready==1.
  - Once high, arvalid and araddr stay stable until arready, independent of buf_ready.
  - First arvalid: at the first edge after cfg_start where buf_ready==1.
  - After a handshake, the next burst may be presented in the following cycle with no bubble.
- Outstanding counter:
  - +1 on arvalid&arready; -1 on rlast_hs; a simultaneous +1 and -1 leaves it unchanged.
  - rlast_hs with outst==0: set err and leave the counter unchanged.
- Completion tracking uses separate counters driven by rlast_hs:
  - blkend pulses with the rlast_hs of the nburst*nrow-th burst of each tile.
  - mapend pulses with the rlast_hs ending the last tile of a channel, coincident with that channel's final blkend.
- The tool does not check 4 KB crossings; the controller guarantees burst alignment.
- Asynchronous reset mid-job aborts the job immediately: all outputs return to reset values and in-flight responses are discarded.

Test Plan:
- Single tile, single channel. Config: BURST_LEN=16, BEAT_BYTES=4, base=0x1000, row_pitch=0x380, nburst=2, nrow=3, nblk=nblkrow=nch=1, arready=buf_ready=1, rlast_hs 3 cycles after each AR.
  -> araddr sequence 0x1000, 0x1040, 0x1380, 0x13C0, 0x1700, 0x1740.
  -> arlen=15, arsize=2, arburst=1.
  -> blkend and mapend on the 6th rlast_hs; done follows.
- Same config with nblk=2, blk_pitch=0x80.
  -> second tile starts at 0x1080.
  -> blkend fires twice; mapend fires only on the 12th rlast_hs.
- nch=2, ch_pitch=0x10000 -> channel 1 first araddr=0x11000; two mapend pulses; one done.
- arready low for 5 cycles -> arvalid and araddr held constant; buf_ready dropping during that wait does not deassert arvalid.
- No rlast_hs returned, MAX_OUTST=4 -> exactly 4 handshakes, then arvalid stays 0 until one rlast_hs arrives.
- Fault and degenerate cases:
  - rlast_hs in IDLE -> err=1, which a following cfg_start clears.
  - nrow=0 -> no AR issued; done one cycle later.
  - rst_n low mid-ISSUE -> arvalid=0 and busy=0 immediately.
